hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide engine that owns the architectural HI/LO registers.
//  It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the execute stage.
//  Results come from an iterative 32-step shift-add multiplier or a 32-step restoring divider.
//  HI/LO drive back to the ALU's HI_input/LO_input. busy stalls the pipeline while an op runs.
// PARAMETERS
//  WIDTH   32  operand and HI/LO width; the iteration count equals WIDTH
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  op_valid  in   1      request strobe; sampled on a clk edge while busy==0
//  op_code   in   3      001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; others are no-op
//  A         in   WIDTH  rs operand (multiplicand / dividend)
//  B         in   WIDTH  rt operand (multiplier / divisor)
//  mt_data   in   WIDTH  value written by MTHI/MTLO
//  busy      out  1      op in flight; HI/LO not yet updated
//  done      out  1      one-cycle pulse after a MULT*/DIV* result is written
//  HI        out  WIDTH  HI register (remainder / product[63:32])
//  LO        out  WIDTH  LO register (quotient / product[31:0])
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous)
//   - HI=0, LO=0, busy=0, done=0, state=IDLE, counter=0.
//   - Asserting reset mid-operation aborts the op; HI/LO go to 0 and no result is written.
//  States: IDLE, RUN, FIX (all registered).
//  IDLE
//   - Edge with op_valid=1 and MTHI: HI<=mt_data at that edge; busy stays 0; no done pulse.
//   - MTLO behaves the same, writing LO.
//   - Edge with op_valid=1 and MULT*/DIV* (edge E0): latch operand magnitudes.
//     Signed ops take |A| and |B|; unsigned ops take raw values.
//     Latch the result signs and clear the counter. Go to RUN; busy=1.
//   - Divide by zero (B==0, DIV or DIVU): go straight to FIX with Q=all-ones and R=A.
//     R=A holds for both DIV and DIVU. No sign correction is applied.
//   - op_valid with an undefined op_code: ignored.
//  RUN: one iteration per edge, WIDTH edges in total (E1..E32 for WIDTH=32); then go to FIX.
//   - Multiply: 2*WIDTH accumulator; if the multiplier LSB is 1, add the multiplicand;
//     then shift the multiplier right and the multiplicand left.
//   - Divide (restoring): shift {R,Q} left 1; if R>=divisor, then R-=divisor and Q[0]=1.
//  FIX (edge E33): apply sign correction and write HI/LO; go to IDLE; busy<=0; done<=1 for 1 cycle.
//   - Signed MULT: negate the 64-bit product if sign(A)^sign(B).
//   - Signed DIV: negate Q if sign(A)^sign(B); negate R if sign(A) (remainder takes the dividend's sign).
//   - DIV of -2^31 by -1 gives LO=0x80000000, HI=0 (natural wrap, no trap).
//  Latency
//   - Normal op: busy high for WIDTH+1 cycles after E0; HI/LO valid from E(WIDTH+1) on.
//   - Divide by zero: busy for 1 cycle.
//  op_valid while busy=1 is ignored; the upstream stall logic must hold the request.
//  HI/LO hold their old values throughout RUN; they update only at FIX or on MTHI/MTLO.
//  done is 0 in every cycle except the one after FIX.
// TESTING
//  MULT A=0xFFFFFFFF B=2 -> after 34 edges HI=0xFFFFFFFF LO=0xFFFFFFFE; done pulses once.
//  MULTU A=0xFFFFFFFF B=2 -> HI=0x00000001 LO=0xFFFFFFFE; busy high for exactly 33 cycles.
//  DIV A=-7 B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
//    DIVU A=7 B=2 -> LO=3, HI=1.
//  DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000 HI=0.
//    DIVU A=5 B=0 -> LO=0xFFFFFFFF HI=5 after 2 edges.
//  MTHI 0x1234 then MTLO 0x5678 on back-to-back edges -> HI=0x1234, LO=0x5678; busy never rises.
//    op_valid MULT during busy -> ignored.
//  Start MULT (HI=0xAA, LO=0xBB preloaded); deassert rst_n at RUN step 10 ->
//    HI=LO=0, busy=0, done=0 asynchronously; next request runs normally.

Source files
------------

// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the execute stage and the HI/LO multiply/divide engine.
// The execute stage is the master; the engine is the slave.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] mt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output op_valid, op_code, A, B, mt_data,
    input  busy, done, HI, LO
  );

  modport slave (
    input  op_valid, op_code, A, B, mt_data,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine owning the HI/LO registers: shift-add multiply,
// restoring divide, WIDTH iterations per operation plus one sign-fix cycle.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hilo_muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] acc_reg;      // product, or {remainder, quotient} while dividing
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;   // multiplier, or divisor while dividing
  logic               is_div_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               busy_reg;
  logic               done_reg;

  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

  // Request decode and operand magnitudes
  logic             op_mul;
  logic             op_div;
  logic             op_mthi;
  logic             op_mtlo;
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_by_zero;

  assign op_mul      = (bus.op_code == OP_MULT) || (bus.op_code == OP_MULTU);
  assign op_div      = (bus.op_code == OP_DIV)  || (bus.op_code == OP_DIVU);
  assign op_mthi     = (bus.op_code == OP_MTHI);
  assign op_mtlo     = (bus.op_code == OP_MTLO);
  assign op_signed   = (bus.op_code == OP_MULT) || (bus.op_code == OP_DIV);
  assign a_neg       = op_signed & bus.A[WIDTH-1];
  assign b_neg       = op_signed & bus.B[WIDTH-1];
  assign a_mag       = a_neg ? (~bus.A + 1'b1) : bus.A;
  assign b_mag       = b_neg ? (~bus.B + 1'b1) : bus.B;
  assign div_by_zero = op_div && (bus.B == '0);

  // One multiply iteration
  logic [2*WIDTH-1:0] mul_acc_next;

  assign mul_acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  // One restoring-divide iteration; rem_diff[WIDTH] is the borrow of the trial subtract
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] div_acc_next;

  assign rem_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign rem_diff  = rem_shift - {1'b0, mplier_reg};

  always_comb begin
    div_acc_next = {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    if (!rem_diff[WIDTH]) begin
      div_acc_next = {rem_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction applied in FIX
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] quo_raw;
  logic [WIDTH-1:0] rem_raw;

  assign quo_raw = acc_reg[WIDTH-1:0];
  assign rem_raw = acc_reg[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_hi = rem_raw;
    fix_lo = quo_raw;
    if (is_div_reg) begin
      if (neg_q_reg) begin
        fix_lo = ~quo_raw + 1'b1;
      end
      if (neg_r_reg) begin
        fix_hi = ~rem_raw + 1'b1;
      end
    end else if (neg_q_reg) begin
      {fix_hi, fix_lo} = ~acc_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.op_valid) begin
            if (op_mthi) begin
              hi_reg <= bus.mt_data;
            end else if (op_mtlo) begin
              lo_reg <= bus.mt_data;
            end else if (op_mul || op_div) begin
              count_reg  <= '0;
              is_div_reg <= op_div;
              mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
              mplier_reg <= b_mag;
              busy_reg   <= 1'b1;
              if (div_by_zero) begin
                // Raw dividend goes to HI and all-ones to LO with no sign fix
                acc_reg   <= {bus.A, {WIDTH{1'b1}}};
                neg_q_reg <= 1'b0;
                neg_r_reg <= 1'b0;
                state_reg <= FIX;
              end else begin
                acc_reg   <= op_div ? {{WIDTH{1'b0}}, a_mag} : '0;
                neg_q_reg <= a_neg ^ b_neg;
                neg_r_reg <= a_neg;
                state_reg <= RUN;
              end
            end
          end
        end

        RUN: begin
          if (is_div_reg) begin
            acc_reg <= div_acc_next;
          end else begin
            acc_reg    <= mul_acc_next;
            mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
          end
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(WIDTH - 1)) begin
            state_reg <= FIX;
          end
        end

        FIX: begin
          hi_reg    <= fix_hi;
          lo_reg    <= fix_lo;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit: stimulus pushes expected HI/LO into a
// scoreboard queue, a monitor pops and compares on every done pulse.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb_q[$];

  hilo_muldiv_if #(.WIDTH(W)) bus ();

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with no pending op, expected none");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_HI"}, bus.HI, e.hi);
        check({e.name, "_LO"}, bus.LO, e.lo);
        $display("op %s: HI=0x%08h LO=0x%08h", e.name, bus.HI, bus.LO);
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] mt);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.A        = a;
    bus.B        = b;
    bus.mt_data  = mt;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'b000;
  endtask

  // Counts negedges with busy high; ends on the negedge where busy has fallen
  task automatic wait_idle(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (bus.busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: busy still high after %0d cycles, expected release", cycles);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input int exp_busy);
    int cyc;
    exp_t e;
    e.hi = exp_hi;
    e.lo = exp_lo;
    e.name = name;
    sb_q.push_back(e);
    drive(op, a, b, '0);
    wait_idle(cyc);
    check({name, "_busy_cycles"}, W'(cyc), W'(exp_busy));
    @(negedge clk);
    check({name, "_done_width"}, W'(bus.done), '0);
  endtask

  initial begin
    int cyc;
    n_cmp        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'b000;
    bus.A        = '0;
    bus.B        = '0;
    bus.mt_data  = '0;

    repeat (2) @(negedge clk);
    check("reset_HI", bus.HI, '0);
    check("reset_LO", bus.LO, '0);
    check("reset_busy", W'(bus.busy), '0);
    check("reset_done", W'(bus.done), '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("MULT_m1x2",   OP_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("MULTU_ffx2",  OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 33);
    run_op("MULT_m3x5",   OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
    run_op("MULTU_shift", OP_MULTU, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800, 33);
    run_op("DIV_m7d2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("DIV_7dm2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    run_op("DIVU_7d2",    OP_DIVU,  32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 33);
    run_op("DIV_minm1",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
    run_op("DIVU_5d0",    OP_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1);
    run_op("DIV_m5d0",    OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);

    // MTHI then MTLO on back-to-back edges
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = OP_MTHI;
    bus.mt_data  = 32'h0000_1234;
    @(posedge clk);
    #1;
    check("mthi_HI", bus.HI, 32'h0000_1234);
    check("mthi_busy", W'(bus.busy), '0);
    bus.op_code = OP_MTLO;
    bus.mt_data = 32'h0000_5678;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'b000;
    check("mtlo_HI", bus.HI, 32'h0000_1234);
    check("mtlo_LO", bus.LO, 32'h0000_5678);
    check("mtlo_busy", W'(bus.busy), '0);
    $display("op MTHI/MTLO: HI=0x%08h LO=0x%08h", bus.HI, bus.LO);

    // Undefined op_code is ignored
    drive(3'b111, 32'd9, 32'd9, 32'hDEAD_BEEF);
    check("undef_busy", W'(bus.busy), '0);
    check("undef_HI", bus.HI, 32'h0000_1234);
    check("undef_LO", bus.LO, 32'h0000_5678);
    $display("op UNDEF: busy=%0b HI=0x%08h LO=0x%08h", bus.busy, bus.HI, bus.LO);

    // A MULT request during busy must be dropped
    begin
      exp_t e;
      e.hi = 32'h0;
      e.lo = 32'd15;
      e.name = "MULTU_3x5_held";
      sb_q.push_back(e);
    end
    drive(OP_MULTU, 32'd3, 32'd5, '0);
    repeat (5) @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = OP_MULT;
    bus.A        = 32'd7;
    bus.B        = 32'd7;
    repeat (3) @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_code  = 3'b000;
    check("held_HI_during_run", bus.HI, 32'h0000_1234);
    check("held_LO_during_run", bus.LO, 32'h0000_5678);
    wait_idle(cyc);
    check("held_busy_cycles", W'(cyc + 8), 32'd33);
    repeat (3) @(negedge clk);
    check("held_no_restart", W'(bus.busy), '0);

    // Reset in the middle of a MULT
    drive(OP_MTHI, '0, '0, 32'h0000_00AA);
    drive(OP_MTLO, '0, '0, 32'h0000_00BB);
    drive(OP_MULT, 32'd100, 32'd200, '0);
    repeat (10) @(negedge clk);
    check("abort_busy_before", W'(bus.busy), 32'd1);
    check("abort_HI_before", bus.HI, 32'h0000_00AA);
    check("abort_LO_before", bus.LO, 32'h0000_00BB);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_HI", bus.HI, '0);
    check("abort_LO", bus.LO, '0);
    check("abort_busy", W'(bus.busy), '0);
    check("abort_done", W'(bus.done), '0);
    $display("op RESET_ABORT: HI=0x%08h LO=0x%08h busy=%0b", bus.HI, bus.LO, bus.busy);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_result_LO", bus.LO, '0);
    run_op("DIVU_after_rst", OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 33);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", W'(sb_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
